// File: rtl/hc595_serializer.sv
// Serialises {seg,sel} words MSB-first into two cascaded 74HC595s, then pulses STCP.
// A single pending slot holds the newest word that arrives while a frame is running.
module hc595_serializer #(
    parameter int DIV   = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             ds,
    output logic             shcp,
    output logic             stcp,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] pend_reg;
    logic             pend_flag;
    logic [7:0]       div_cnt;
    logic             phase;
    logic [BW-1:0]    bit_cnt;

    assign ds = sreg[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            pend_reg  <= '0;
            pend_flag <= 1'b0;
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            shcp      <= 1'b0;
            stcp      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobes during a frame (including the last LATCH cycle) overwrite the pending slot
            if (din_vld && state != IDLE) begin
                pend_reg  <= din;
                pend_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (din_vld || pend_flag) begin
                        sreg      <= din_vld ? din : pend_reg;
                        pend_flag <= 1'b0;
                        state     <= SHIFT;
                        div_cnt   <= '0;
                        phase     <= 1'b0;
                        bit_cnt   <= '0;
                        shcp      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                            shcp  <= 1'b1;
                        end else begin
                            // Falling SHCP edge ends the bit; next bit appears on DS together with it
                            phase <= 1'b0;
                            shcp  <= 1'b0;
                            sreg  <= {sreg[WIDTH-2:0], 1'b0};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                stcp    <= 1'b1;
                                state   <= LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        stcp    <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
